// File: rtl/pipeline_hazard_ctrl_pkg.sv
// mips_pipe_pkg: shared pipeline-control types and constants for the MIPS core
package mips_pipe_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MULDIV = 2'd1, FLUSH = 2'd2} state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int WB_W = 2;
  localparam int MEM_W = 3;
  localparam int EX_W = 4;
  localparam int CTRL_W = WB_W + MEM_W + EX_W;
  function automatic logic [CTRL_W-1:0] bubble_ctrl(input logic bubble, input logic [CTRL_W-1:0] ctrl);
    return bubble ? '0 : ctrl;
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID/EX hazard inputs and front-end control outputs
//   slave  (controller): hazard inputs in; pcWrite/ifIdWrite/ifIdFlush/idExBubble/mulDivBusy/stallCycles out
//   master (pipeline)  : the reverse
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic idUsesRt;
  logic idMulDiv;
  logic exMemRead;
  logic [4:0] exRegTarget;
  logic branchTaken;
  logic pcWrite;
  logic ifIdWrite;
  logic ifIdFlush;
  logic idExBubble;
  logic mulDivBusy;
  logic [CNT_W-1:0] stallCycles;
  modport slave (
    input idRs, idRt, idUsesRt, idMulDiv, exMemRead, exRegTarget, branchTaken,
    output pcWrite, ifIdWrite, ifIdFlush, idExBubble, mulDivBusy, stallCycles
  );
  modport master (
    output idRs, idRt, idUsesRt, idMulDiv, exMemRead, exRegTarget, branchTaken,
    input pcWrite, ifIdWrite, ifIdFlush, idExBubble, mulDivBusy, stallCycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// load_use_detect: flags an ID source register written by a load still in EX
//   in : ex_mem_read, ex_reg_target, id_rs, id_rt, id_uses_rt   out: load_use
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_reg_target,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);
  assign load_use = ex_mem_read && (ex_reg_target != REG_ZERO) &&
                    ((ex_reg_target == id_rs) || (id_uses_rt && ex_reg_target == id_rt));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: IF/ID and ID/EX sequencing for load-use stalls, mult/div holds and branch flushes
//   clock, reset (sync, active-high); bus: hazard inputs in, register enables/flush/bubble/busy/stall count out
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W = 32
) (
  input logic clock,
  input logic reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int MAXC = (MULDIV_LATENCY > BRANCH_PENALTY) ? MULDIV_LATENCY : BRANCH_PENALTY;
  localparam int CW = $clog2(MAXC + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic load_use;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, mul_div_busy;
  load_use_detect u_lud (
    .ex_mem_read  (bus.exMemRead),
    .ex_reg_target(bus.exRegTarget),
    .id_rs        (bus.idRs),
    .id_rt        (bus.idRt),
    .id_uses_rt   (bus.idUsesRt),
    .load_use     (load_use)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pc_write = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_bubble = 1'b0;
    mul_div_busy = 1'b0;
    if (reset) begin
      pc_write = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
      state_d = RUN;
      cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.branchTaken) begin
            if_id_flush = 1'b1;
            id_ex_bubble = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              state_d = FLUSH;
              cnt_d = CW'(BRANCH_PENALTY - 2);
            end
          end else if (load_use) begin
            pc_write = 1'b0;
            if_id_write = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (bus.idMulDiv) begin
            state_d = MULDIV;
            cnt_d = CW'(MULDIV_LATENCY - 1);
          end
        end
        MULDIV: begin
          pc_write = 1'b0;
          if_id_write = 1'b0;
          id_ex_bubble = 1'b1;
          mul_div_busy = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = RUN;
            cnt_d = '0;
          end
        end
        FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = RUN;
            cnt_d = '0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d = '0;
        end
      endcase
    end
    stall_d = reset ? '0 : (!pc_write && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
  end
  always_ff @(posedge clock) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    stall_q <= stall_d;
  end
  assign bus.pcWrite = pc_write;
  assign bus.ifIdWrite = if_id_write;
  assign bus.ifIdFlush = if_id_flush;
  assign bus.idExBubble = id_ex_bubble;
  assign bus.mulDivBusy = mul_div_busy;
  assign bus.stallCycles = stall_q;
endmodule
